// File: rtl/tiger_icache_word_streamer.sv
// -----------------------------------------------------------------------------
// tiger_icache_word_streamer
//
// Purpose:
//   Registered, handshaked line-to-word streamer sitting between the icache
//   line store / SDRAM refill path and the Tiger fetch stage. A full cache
//   line is captured in one handshake. The line is then emitted one word per
//   handshake, either as a wrap-around burst of M words that starts at the
//   critical word, or as a single selected word.
//
// Parameters:
//   N  word width in bits
//   M  words per line (M >= 2)
//   S  select width, ceil(log2(M))
//   W  line width, M*N (derived)
//
// Ports:
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   flush       synchronous abort, drops the current line
//   line_valid  line_data / start_sel / mode are valid
//   line_ready  block can accept a line (state IDLE)
//   line_data   line, word k in bits [N*k+N-1 : N*k]
//   start_sel   index of the first word to emit
//   mode        0 = wrap burst of M words, 1 = single word
//   word_valid  word_data is valid (state STREAM)
//   word_ready  consumer accepts the word
//   word_data   current word, taken from the line buffer
//   word_idx    index of the current word within the line
//   word_last   current word is the final one of this line
//   busy        a line is held (state STREAM)
// -----------------------------------------------------------------------------
module tiger_icache_word_streamer #(
   parameter int N = 32,
   parameter int M = 8,
   parameter int S = 3,
   localparam int W = M * N
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         flush,
   input  logic         line_valid,
   output logic         line_ready,
   input  logic [W-1:0] line_data,
   input  logic [S-1:0] start_sel,
   input  logic         mode,
   output logic         word_valid,
   input  logic         word_ready,
   output logic [N-1:0] word_data,
   output logic [S-1:0] word_idx,
   output logic         word_last,
   output logic         busy
);

   // remaining must be able to hold the full burst length M
   localparam int R = $clog2(M + 1);

   localparam logic [S-1:0] PTR_MAX   = S'(M - 1);
   localparam logic [R-1:0] BURST_LEN = R'(M);
   localparam logic [R-1:0] ONE_WORD  = R'(1);

   typedef enum logic {
      IDLE,
      STREAM
   } state_t;

   state_t         state;
   logic [S-1:0]   ptr;
   logic [R-1:0]   remaining;
   logic [N-1:0]   line_buf [M];

   logic           line_accept;
   logic           word_accept;

   // An out-of-range start index (only possible when M is not a power of two)
   // restarts the burst at word 0 instead of addressing a non-existent word.
   function automatic logic [S-1:0] clamp_sel(input logic [S-1:0] sel);
      if ({1'b0, sel} > {1'b0, PTR_MAX})
         return '0;
      else
         return sel;
   endfunction

   // Modulo-M increment so every index is visited exactly once per burst.
   function automatic logic [S-1:0] next_ptr(input logic [S-1:0] cur);
      if (cur == PTR_MAX)
         return '0;
      else
         return cur + S'(1);
   endfunction

   function automatic logic [R-1:0] burst_len(input logic single);
      return single ? ONE_WORD : BURST_LEN;
   endfunction

   assign line_ready = (state == IDLE);
   assign word_valid = (state == STREAM);
   assign busy       = (state == STREAM);

   // flush overrides both handshakes in the same cycle
   assign line_accept = line_valid && line_ready && !flush;
   assign word_accept = word_valid && word_ready && !flush;

   // Outputs come only from registered state; line_data never reaches them.
   assign word_data = line_buf[ptr];
   assign word_idx  = ptr;
   assign word_last = (remaining == ONE_WORD);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         ptr       <= '0;
         remaining <= '0;
      end else if (flush) begin
         state     <= IDLE;
         ptr       <= '0;
         remaining <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (line_accept) begin
                  state     <= STREAM;
                  ptr       <= clamp_sel(start_sel);
                  remaining <= burst_len(mode);
               end
            end
            STREAM: begin
               if (word_accept) begin
                  ptr       <= next_ptr(ptr);
                  remaining <= remaining - ONE_WORD;
                  // going back to IDLE here makes the next line wait a cycle
                  if (word_last)
                     state <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               ptr       <= '0;
               remaining <= '0;
            end
         endcase
      end
   end

   // Line buffer: loaded only on the accept edge, untouched by flush so the
   // last line stays visible for debug.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < M; k++)
            line_buf[k] <= '0;
      end else if (line_accept) begin
         for (int k = 0; k < M; k++)
            line_buf[k] <= line_data[k*N +: N];
      end
   end

endmodule

// File: tb/tb_tiger_icache_word_streamer.sv
// -----------------------------------------------------------------------------
// tb_tiger_icache_word_streamer
//
// Directed bench for tiger_icache_word_streamer. Two instances: one with the
// default power-of-two line (M = 8) and one with M = 6 to cover start index
// clamping and modulo-6 wrap. Expected values are hand-derived constants.
// -----------------------------------------------------------------------------
module tb_tiger_icache_word_streamer;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         flush;
   logic [2:0]   start_sel;
   logic         mode;
   logic         word_ready;

   // M = 8 instance
   logic         line_valid;
   logic         line_ready;
   logic [255:0] line_data;
   logic         word_valid;
   logic [31:0]  word_data;
   logic [2:0]   word_idx;
   logic         word_last;
   logic         busy;

   // M = 6 instance
   logic         line_valid6;
   logic         line_ready6;
   logic [191:0] line_data6;
   logic         word_valid6;
   logic [31:0]  word_data6;
   logic [2:0]   word_idx6;
   logic         word_last6;
   logic         busy6;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   tiger_icache_word_streamer #(.N(32), .M(8), .S(3)) dut8 (
      .clk        (clk),
      .reset_n    (reset_n),
      .flush      (flush),
      .line_valid (line_valid),
      .line_ready (line_ready),
      .line_data  (line_data),
      .start_sel  (start_sel),
      .mode       (mode),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .word_data  (word_data),
      .word_idx   (word_idx),
      .word_last  (word_last),
      .busy       (busy)
   );

   tiger_icache_word_streamer #(.N(32), .M(6), .S(3)) dut6 (
      .clk        (clk),
      .reset_n    (reset_n),
      .flush      (flush),
      .line_valid (line_valid6),
      .line_ready (line_ready6),
      .line_data  (line_data6),
      .start_sel  (start_sel),
      .mode       (mode),
      .word_valid (word_valid6),
      .word_ready (word_ready),
      .word_data  (word_data6),
      .word_idx   (word_idx6),
      .word_last  (word_last6),
      .busy       (busy6)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Load a line whose word k is base+k, then stream it with word_ready high
   // and check index, data and last flag on every cycle.
   task automatic run_wrap(input bit six, input logic [2:0] start, input int first,
                           input logic [31:0] base);
      int m;
      int idx;
      m = six ? 6 : 8;
      for (int k = 0; k < 8; k++) line_data[k*32 +: 32] = base + 32'(k);
      for (int k = 0; k < 6; k++) line_data6[k*32 +: 32] = base + 32'(k);
      start_sel  = start;
      mode       = 1'b0;
      word_ready = 1'b1;
      if (six) line_valid6 = 1'b1; else line_valid = 1'b1;
      chk("wrap_line_ready", 64'(six ? line_ready6 : line_ready), 64'd1);
      tick();
      line_valid  = 1'b0;
      line_valid6 = 1'b0;
      // the buffer must not follow line_data after the accept edge
      line_data   = '1;
      line_data6  = '1;
      for (int i = 0; i < m; i++) begin
         idx = (first + i) % m;
         chk("wrap_valid", 64'(six ? word_valid6 : word_valid), 64'd1);
         chk("wrap_idx",   64'(six ? word_idx6 : word_idx), 64'(idx));
         chk("wrap_data",  64'(six ? word_data6 : word_data), 64'(base + 32'(idx)));
         chk("wrap_last",  64'(six ? word_last6 : word_last), 64'(i == m - 1));
         tick();
      end
      chk("wrap_end_valid", 64'(six ? word_valid6 : word_valid), 64'd0);
      chk("wrap_end_ready", 64'(six ? line_ready6 : line_ready), 64'd1);
   endtask

   initial begin
      int k;
      int cyc;
      bit rdy;
      logic [31:0] held;

      reset_n     = 1'b0;
      flush       = 1'b0;
      start_sel   = '0;
      mode        = 1'b0;
      word_ready  = 1'b0;
      line_valid  = 1'b0;
      line_valid6 = 1'b0;
      line_data   = '0;
      line_data6  = '0;

      // ---------------- reset state ----------------
      repeat (2) @(posedge clk);
      #1;
      chk("rst_line_ready", 64'(line_ready), 64'd1);
      chk("rst_word_valid", 64'(word_valid), 64'd0);
      chk("rst_busy",       64'(busy),       64'd0);
      chk("rst_word_data",  64'(word_data),  64'd0);
      chk("rst_word_idx",   64'(word_idx),   64'd0);
      chk("rst_word_last",  64'(word_last),  64'd0);
      reset_n = 1'b1;
      tick();
      chk("post_rst_ready", 64'(line_ready), 64'd1);

      // ---------------- wrap burst M=8, start 5 ----------------
      run_wrap(1'b0, 3'd5, 5, 32'h100);

      // ---------------- single word, start 3 ----------------
      for (int j = 0; j < 8; j++) line_data[j*32 +: 32] = 32'h100 + 32'(j);
      start_sel  = 3'd3;
      mode       = 1'b1;
      word_ready = 1'b1;
      line_valid = 1'b1;
      tick();
      line_valid = 1'b0;
      chk("single_valid", 64'(word_valid), 64'd1);
      chk("single_data",  64'(word_data),  64'h103);
      chk("single_idx",   64'(word_idx),   64'd3);
      chk("single_last",  64'(word_last),  64'd1);
      tick();
      chk("single_done",  64'(word_valid), 64'd0);

      // ---------------- back-pressure, ready 1,0,0,... ----------------
      for (int j = 0; j < 8; j++) line_data[j*32 +: 32] = 32'h200 + 32'(j);
      start_sel  = 3'd2;
      mode       = 1'b0;
      line_valid = 1'b1;
      word_ready = 1'b0;
      tick();
      line_valid = 1'b0;
      k   = 0;
      cyc = 0;
      held = word_data;
      while (k < 8 && cyc < 40) begin
         rdy = (cyc % 3) == 0;
         word_ready = rdy;
         chk("bp_valid", 64'(word_valid), 64'd1);
         chk("bp_idx",   64'(word_idx),   64'((2 + k) % 8));
         chk("bp_data",  64'(word_data),  64'(32'h200 + 32'((2 + k) % 8)));
         chk("bp_last",  64'(word_last),  64'(k == 7));
         if (rdy) k++;
         tick();
         cyc++;
      end
      chk("bp_handshakes", 64'(k), 64'd8);
      chk("bp_done_valid", 64'(word_valid), 64'd0);
      word_ready = 1'b1;

      // ---------------- flush during burst ----------------
      for (int j = 0; j < 8; j++) line_data[j*32 +: 32] = 32'h100 + 32'(j);
      start_sel  = 3'd0;
      mode       = 1'b0;
      line_valid = 1'b1;
      tick();
      line_valid = 1'b0;
      chk("fl_idx0", 64'(word_idx), 64'd0);
      tick();
      chk("fl_idx1", 64'(word_idx), 64'd1);
      tick();
      chk("fl_idx2", 64'(word_idx), 64'd2);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("fl_valid", 64'(word_valid), 64'd0);
      chk("fl_ready", 64'(line_ready), 64'd1);
      chk("fl_idx",   64'(word_idx),   64'd0);
      chk("fl_last",  64'(word_last),  64'd0);

      // ---------------- flush with line_valid in IDLE ----------------
      start_sel  = 3'd3;
      mode       = 1'b1;
      line_valid = 1'b1;
      flush      = 1'b1;
      tick();
      chk("fl_idle_busy", 64'(busy), 64'd0);
      flush = 1'b0;
      tick();
      line_valid = 1'b0;
      chk("fl_retry_busy", 64'(busy),      64'd1);
      chk("fl_retry_data", 64'(word_data), 64'h103);
      chk("fl_retry_last", 64'(word_last), 64'd1);
      tick();
      chk("fl_retry_done", 64'(busy), 64'd0);

      // ---------------- reset mid-burst ----------------
      for (int j = 0; j < 8; j++) line_data[j*32 +: 32] = 32'h400 + 32'(j);
      start_sel  = 3'd1;
      mode       = 1'b0;
      line_valid = 1'b1;
      tick();
      line_valid = 1'b0;
      tick();
      chk("mid_pre_idx", 64'(word_idx), 64'd2);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(word_valid), 64'd0);
      chk("mid_rst_ready", 64'(line_ready), 64'd1);
      chk("mid_rst_data",  64'(word_data),  64'd0);
      chk("mid_rst_idx",   64'(word_idx),   64'd0);
      chk("mid_rst_last",  64'(word_last),  64'd0);
      chk("mid_rst_busy",  64'(busy),       64'd0);
      #2;
      reset_n = 1'b1;
      tick();
      chk("mid_post_valid", 64'(word_valid), 64'd0);
      chk("mid_post_ready", 64'(line_ready), 64'd1);

      // ---------------- M=6: out-of-range start and wrap ----------------
      run_wrap(1'b1, 3'd7, 0, 32'h300);
      run_wrap(1'b1, 3'd4, 4, 32'h300);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // global watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

endmodule
